// File: rtl/code_ser_pkg.sv
// Shared definitions for the code-word serializer: FSM state encoding and default word width.
package code_ser_pkg;

    localparam int CODE_WIDTH_DEFAULT = 10;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        GAP    = 3'd5
    } ser_state_e;

endpackage

// File: rtl/code_ser_if.sv
// Valid/ready code-word handshake between the code-word generator and the serializer.
interface code_ser_if #(
    parameter int CODE_WIDTH = code_ser_pkg::CODE_WIDTH_DEFAULT
);

    logic [CODE_WIDTH-1:0] code_in;
    logic                  code_valid;
    logic                  code_ready;

    modport master (output code_in, output code_valid, input code_ready);
    modport slave  (input code_in, input code_valid, output code_ready);

endinterface

// File: rtl/code_ser_fifo.sv
// Synchronous FIFO with extra-MSB pointers; a push while full is ignored, a pop while empty is ignored.
module code_ser_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic                     sysclk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             do_push;
    logic             do_pop;

    // Same index with differing wrap bits means the write side has lapped the read side.
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign empty   = (wptr == rptr);
    assign level   = wptr - rptr;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr[AW-1:0]];

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge sysclk) begin
        if (do_push) mem[wptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/code_word_serializer.sv
// Buffers code words and shifts each out LSB-first as a start/data/stop framed stream on ser_en.
// Define CODE_SER_PARITY_EN to append an even-parity bit between the data and the stop bit.
module code_word_serializer
    import code_ser_pkg::*;
#(
    parameter int CODE_WIDTH = CODE_WIDTH_DEFAULT,
    parameter int FIFO_DEPTH = 4,
    parameter int IDLE_GAP   = 2
) (
    input  logic                          sysclk,
    input  logic                          reset,
    code_ser_if.slave                     up,
    input  logic                          ser_en,
    output logic                          ser_out,
    output logic                          ser_frame,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow
);

    localparam int CNT_W = $clog2(CODE_WIDTH + IDLE_GAP + 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(CODE_WIDTH - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((IDLE_GAP > 0) ? IDLE_GAP - 1 : 0);

    localparam logic [2:0] ST_IDLE   = IDLE;
    localparam logic [2:0] ST_START  = START;
    localparam logic [2:0] ST_DATA   = DATA;
`ifdef CODE_SER_PARITY_EN
    localparam logic [2:0] ST_PARITY = PARITY;
`endif
    localparam logic [2:0] ST_STOP   = STOP;
    localparam logic [2:0] ST_GAP    = GAP;

    logic [2:0]            state;
    logic [CNT_W-1:0]      count;
    logic [CODE_WIDTH-1:0] shift;
    logic [CODE_WIDTH-1:0] head;
    logic                  full;
    logic                  empty;
    logic                  frame_end;
    logic                  load;
`ifdef CODE_SER_PARITY_EN
    logic                  parity;
`endif

    code_ser_fifo #(
        .WIDTH (CODE_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .sysclk (sysclk),
        .reset  (reset),
        .push   (up.code_valid),
        .wdata  (up.code_in),
        .pop    (load),
        .rdata  (head),
        .full   (full),
        .empty  (empty),
        .level  (fifo_level)
    );

    assign up.code_ready = !full;

    // The last bit-time of a frame chains straight into the next start bit, so
    // back-to-back frames are separated by exactly IDLE_GAP marks.
    always_comb begin
        frame_end = 1'b0;
        case (state)
            ST_IDLE: frame_end = 1'b1;
            ST_STOP: frame_end = (IDLE_GAP == 0);
            ST_GAP:  frame_end = (count == GAP_LAST);
            default: frame_end = 1'b0;
        endcase
        load = ser_en && frame_end && !empty;
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            count     <= '0;
            shift     <= '0;
            ser_out   <= 1'b1;
            ser_frame <= 1'b0;
`ifdef CODE_SER_PARITY_EN
            parity    <= 1'b0;
`endif
        end else if (ser_en) begin
            if (frame_end) begin
                if (load) begin
                    state     <= ST_START;
                    shift     <= head;
                    ser_out   <= 1'b0;
                    ser_frame <= 1'b1;
`ifdef CODE_SER_PARITY_EN
                    parity    <= ^head;
`endif
                end else begin
                    state     <= ST_IDLE;
                    ser_out   <= 1'b1;
                    ser_frame <= 1'b0;
                end
            end else begin
                case (state)
                    ST_START: begin
                        state   <= ST_DATA;
                        count   <= '0;
                        ser_out <= shift[0];
                        shift   <= {1'b0, shift[CODE_WIDTH-1:1]};
                    end
                    ST_DATA: begin
                        if (count == DATA_LAST) begin
`ifdef CODE_SER_PARITY_EN
                            state   <= ST_PARITY;
                            ser_out <= parity;
`else
                            state   <= ST_STOP;
                            ser_out <= 1'b1;
`endif
                        end else begin
                            count   <= count + 1'b1;
                            ser_out <= shift[0];
                            shift   <= {1'b0, shift[CODE_WIDTH-1:1]};
                        end
                    end
`ifdef CODE_SER_PARITY_EN
                    ST_PARITY: begin
                        state   <= ST_STOP;
                        ser_out <= 1'b1;
                    end
`endif
                    ST_STOP: begin
                        state     <= ST_GAP;
                        count     <= '0;
                        ser_out   <= 1'b1;
                        ser_frame <= 1'b0;
                    end
                    ST_GAP: begin
                        count <= count + 1'b1;
                    end
                    default: begin
                        state     <= ST_IDLE;
                        ser_out   <= 1'b1;
                        ser_frame <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Sticky until reset so an upstream protocol slip is never lost.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (up.code_valid && !up.code_ready) begin
            overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_code_word_serializer.sv
// Directed self-checking bench for code_word_serializer; expectations follow CODE_SER_PARITY_EN.
module tb_code_word_serializer;

    localparam int W     = 10;
    localparam int DEPTH = 4;
    localparam int GAPB  = 2;
`ifdef CODE_SER_PARITY_EN
    localparam int PAR = 1;
    localparam logic [12:0] HAND_2A5 = 13'b0101001010111;
`else
    localparam int PAR = 0;
    localparam logic [12:0] HAND_2A5 = 13'b0010100101011;
`endif
    localparam int FRAME_BITS = W + 2 + PAR;

    logic       sysclk = 1'b0;
    logic       reset;
    logic       ser_en;
    logic       ser_out;
    logic       ser_frame;
    logic [2:0] fifo_level;
    logic       overflow;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int en_period = 1;

    code_ser_if #(.CODE_WIDTH(W)) up ();

    code_word_serializer #(
        .CODE_WIDTH (W),
        .FIFO_DEPTH (DEPTH),
        .IDLE_GAP   (GAPB)
    ) dut (
        .sysclk     (sysclk),
        .reset      (reset),
        .up         (up),
        .ser_en     (ser_en),
        .ser_out    (ser_out),
        .ser_frame  (ser_frame),
        .fifo_level (fifo_level),
        .overflow   (overflow)
    );

    always #5 sysclk = ~sysclk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One sysclk cycle; ser_en follows the current strobe period.
    task automatic tick(output logic had_en);
        ser_en = (en_period == 0) ? 1'b0 : ((cyc % en_period) == 0);
        had_en = ser_en;
        @(posedge sysclk);
        #1;
        cyc++;
    endtask

    task automatic bit_step(input string tag);
        logic e;
        int   n;
        e = 1'b0;
        n = 0;
        while (!e && n < 20) begin
            tick(e);
            n++;
        end
        check_output({tag, "_strobe"}, e, 1);
    endtask

    task automatic apply_stimulus(input logic [W-1:0] word);
        logic e;
        up.code_in    = word;
        up.code_valid = 1'b1;
        tick(e);
    endtask

    function automatic logic exp_bit(input logic [W-1:0] word, input int k);
        if (k == 0) return 1'b0;
        if (k <= W) return word[k-1];
        if (PAR == 1 && k == W + 1) return ^word;
        return 1'b1;
    endfunction

    // Walks one whole frame plus its gap, comparing every bit-time against the model.
    task automatic check_frame(input logic [W-1:0] word, input logic immediate, output logic [12:0] cap);
        logic e;
        int   n;
        cap = '0;
        if (immediate) begin
            bit_step("next_start");
        end else begin
            n = 0;
            while (!ser_frame && n < 200) begin
                tick(e);
                n++;
            end
        end
        check_output($sformatf("start_frame_%03h", word), ser_frame, 1);
        for (int k = 0; k < FRAME_BITS; k++) begin
            if (k > 0) bit_step("bit");
            check_output($sformatf("ser_out_%03h_b%0d", word, k), ser_out, exp_bit(word, k));
            check_output($sformatf("ser_frame_%03h_b%0d", word, k), ser_frame, 1);
            cap = {cap[11:0], ser_out};
        end
        for (int g = 0; g < GAPB; g++) begin
            bit_step("gap");
            check_output($sformatf("gap_out_%03h_%0d", word, g), ser_out, 1);
            check_output($sformatf("gap_frame_%03h_%0d", word, g), ser_frame, 0);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic        e;
        logic [12:0] cap;
        logic [W-1:0] words [5];
        int          lvl_exp [5];
        int          rdy_exp [5];
        int          ovf_exp [5];

        words   = '{10'h111, 10'h222, 10'h333, 10'h0F0, 10'h3C3};
        lvl_exp = '{1, 2, 3, 4, 4};
        rdy_exp = '{1, 1, 1, 0, 0};
        ovf_exp = '{0, 0, 0, 0, 1};

        reset         = 1'b1;
        ser_en        = 1'b0;
        up.code_in    = '0;
        up.code_valid = 1'b0;
        repeat (2) @(posedge sysclk);
        #1;
        check_output("rst_ser_out", ser_out, 1);
        check_output("rst_ser_frame", ser_frame, 0);
        check_output("rst_level", fifo_level, 0);
        check_output("rst_ready", up.code_ready, 1);
        check_output("rst_overflow", overflow, 0);
        @(negedge sysclk);
        reset = 1'b0;

        // Idle line with the strobe running and nothing queued.
        en_period = 1;
        for (int i = 0; i < 50; i++) begin
            tick(e);
            check_output("idle_ser_out", ser_out, 1);
            check_output("idle_ser_frame", ser_frame, 0);
            check_output("idle_ready", up.code_ready, 1);
            check_output("idle_level", fifo_level, 0);
        end

        // Single word 2A5: one-cycle write latency then the start bit.
        apply_stimulus(10'h2A5);
        up.code_valid = 1'b0;
        check_output("lat_level_after_push", fifo_level, 1);
        check_output("lat_no_start_yet", ser_out, 1);
        check_output("lat_frame_low", ser_frame, 0);
        tick(e);
        check_output("lat_start_bit", ser_out, 0);
        check_output("lat_frame_high", ser_frame, 1);
        check_output("lat_level_popped", fifo_level, 0);
        check_frame(10'h2A5, 1'b0, cap);
        check_output("hand_2a5_frame", cap, HAND_2A5);

        // Strobe held off: fill the FIFO, overflow on the fifth push.
        en_period = 0;
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(words[i]);
            check_output($sformatf("fill_level_%0d", i), fifo_level, lvl_exp[i]);
            check_output($sformatf("fill_ready_%0d", i), up.code_ready, rdy_exp[i]);
            check_output($sformatf("fill_overflow_%0d", i), overflow, ovf_exp[i]);
        end
        up.code_valid = 1'b0;
        en_period = 1;
        cyc = 0;
        check_frame(words[0], 1'b0, cap);
        check_frame(words[1], 1'b1, cap);
        check_frame(words[2], 1'b1, cap);
        check_frame(words[3], 1'b1, cap);
        for (int i = 0; i < 6; i++) begin
            tick(e);
            check_output("drain_frame_low", ser_frame, 0);
        end
        check_output("drain_level", fifo_level, 0);
        check_output("overflow_sticky", overflow, 1);

        // Back-to-back words with the strobe on every third cycle.
        en_period = 3;
        cyc = 0;
        apply_stimulus(10'h001);
        apply_stimulus(10'h3FF);
        up.code_valid = 1'b0;
        check_output("b2b_ready", up.code_ready, 1);
        check_frame(10'h001, 1'b0, cap);
        check_frame(10'h3FF, 1'b1, cap);

        // Reset while the fourth data bit (a 0) is on the line and a word is queued.
        en_period = 1;
        cyc = 0;
        apply_stimulus(10'h155);
        apply_stimulus(10'h0CC);
        up.code_valid = 1'b0;
        check_output("pre_rst_start", ser_out, 0);
        check_output("pre_rst_level", fifo_level, 1);
        for (int i = 0; i < 4; i++) bit_step("pre_rst");
        check_output("pre_rst_bit3", ser_out, 0);
        check_output("pre_rst_frame", ser_frame, 1);
        #2;
        reset = 1'b1;
        #1;
        check_output("async_rst_ser_out", ser_out, 1);
        check_output("async_rst_frame", ser_frame, 0);
        check_output("async_rst_level", fifo_level, 0);
        check_output("async_rst_overflow", overflow, 0);
        check_output("async_rst_ready", up.code_ready, 1);
        @(negedge sysclk);
        reset = 1'b0;
        apply_stimulus(10'h2D2);
        up.code_valid = 1'b0;
        check_frame(10'h2D2, 1'b0, cap);
        for (int i = 0; i < 20; i++) begin
            tick(e);
            check_output("post_rst_no_stale", ser_frame, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
